// File: rtl/gpio_port_pkg.sv
// rtl/gpio_port_pkg.sv - gpio_port register map constants shared by the RTL slice
package gpio_port_pkg;

    typedef logic [2:0] gpio_addr_t;

    localparam gpio_addr_t GPIO_OUT   = 3'd0;
    localparam gpio_addr_t GPIO_DIR   = 3'd1;
    localparam gpio_addr_t GPIO_IN    = 3'd2;
    localparam gpio_addr_t GPIO_EVENT = 3'd3;
    localparam gpio_addr_t GPIO_MASK  = 3'd4;

    localparam logic [31:0] GPIO_RDATA_RST = 32'h0000_0000;

endpackage

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - 2-flop pad synchroniser with optional previous-value flop for rise detect
// Macro GPIO_EDGE_EVENT_EN adds the previous-value flop and the o_rise output.
module gpio_sync #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    input  logic [WIDTH-1:0] i_pad,
`ifdef GPIO_EDGE_EVENT_EN
    output logic [WIDTH-1:0] o_rise,
`endif
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else if (i_clk_en) begin
            r_meta <= i_pad;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

`ifdef GPIO_EDGE_EVENT_EN
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= '0;
        end else if (i_clk_en) begin
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
`endif

endmodule

// File: rtl/gpio_port.sv
// rtl/gpio_port.sv - memory-mapped GPIO port: OUT/DIR/IN registers, pads, registered read data
// Macro GPIO_EDGE_EVENT_EN builds the EVENT/MASK registers and the o_irq output.
module gpio_port
    import gpio_port_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_OUT = 32'h0000_0000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    input  logic [2:0]       i_addr,
    input  logic [31:0]      i_wdata,
    input  logic             i_we,
    input  logic             i_re,
    output logic [31:0]      o_rdata,
    output logic             o_irq,
    inout  wire  [WIDTH-1:0] io_gpio
);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] w_sync;
    logic [31:0]      r_rdata;
    logic [31:0]      w_rdata;

`ifdef GPIO_EDGE_EVENT_EN
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_ev_clr;
    logic [WIDTH-1:0] r_event;
    logic [WIDTH-1:0] r_mask;
    logic             r_irq;
`endif

    gpio_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clk_en (i_clk_en),
        .i_pad    (io_gpio),
`ifdef GPIO_EDGE_EVENT_EN
        .o_rise   (w_rise),
`endif
        .o_sync   (w_sync)
    );

    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        assign io_gpio[g] = r_dir[g] ? r_out[g] : 1'bz;
    end

    // Read mux sees pre-write register values, so a same-cycle write/read returns old data.
    always_comb begin
        w_rdata = '0;
        case (i_addr)
            GPIO_OUT:   w_rdata[WIDTH-1:0] = r_out;
            GPIO_DIR:   w_rdata[WIDTH-1:0] = r_dir;
            GPIO_IN:    w_rdata[WIDTH-1:0] = w_sync;
`ifdef GPIO_EDGE_EVENT_EN
            GPIO_EVENT: w_rdata[WIDTH-1:0] = r_event;
            GPIO_MASK:  w_rdata[WIDTH-1:0] = r_mask;
`else
            GPIO_EVENT: w_rdata = '0;
            GPIO_MASK:  w_rdata = '0;
`endif
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out   <= RESET_OUT[WIDTH-1:0];
            r_dir   <= '0;
            r_rdata <= GPIO_RDATA_RST;
        end else if (i_clk_en) begin
            if (i_we) begin
                case (i_addr)
                    GPIO_OUT: r_out <= i_wdata[WIDTH-1:0];
                    GPIO_DIR: r_dir <= i_wdata[WIDTH-1:0];
                    default:  ;
                endcase
            end
            if (i_re) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign o_rdata = r_rdata;

`ifdef GPIO_EDGE_EVENT_EN
    assign w_ev_clr = (i_we && (i_addr == GPIO_EVENT)) ? i_wdata[WIDTH-1:0] : '0;

    // A new edge in the same cycle as its W1C clear keeps the bit set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_event <= '0;
            r_mask  <= '0;
            r_irq   <= 1'b0;
        end else if (i_clk_en) begin
            r_event <= (r_event & ~w_ev_clr) | w_rise;
            if (i_we && (i_addr == GPIO_MASK)) begin
                r_mask <= i_wdata[WIDTH-1:0];
            end
            r_irq <= |(r_event & r_mask);
        end
    end

    assign o_irq = r_irq;
`else
    assign o_irq = 1'b0;
`endif

endmodule
